mcycle_unit: RTL



---
 rtl/mcycle_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit for the Execute stage.
// One radix-2 step per cycle over WIDTH cycles: shift-add for multiply,
// restoring shift-subtract for divide. Signed operations run on magnitudes
// and receive their sign fix-up on the way into the result registers.
// Handshake: an operation is accepted in any cycle where Start=1 and the unit
// is not computing. Busy is high from the accepting cycle until the last
// compute cycle. Done pulses for one cycle when Result1/Result2 become valid.
module mcycle_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   // Visible FSM state for checkers and waveform debug.
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic             div_zero_q, div_zero_d;
   // hi: product upper half / partial remainder.
   // lo: multiplier being consumed / dividend shifting out, quotient shifting in.
   // b:  multiplicand / divisor magnitude.
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res1_q, res1_d;
   logic [WIDTH-1:0] res2_q, res2_d;
   logic             done_q, done_d;

   logic             accept;
   logic             op1_neg, op2_neg;
   logic [WIDTH-1:0] op1_abs, op2_abs;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_rem;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] hi_n, lo_n;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] fix1, fix2;

   assign accept  = Start && (state_q != S_COMPUTE);
   assign Busy    = accept || (state_q == S_COMPUTE);
   assign Done    = done_q;
   assign Result1 = res1_q;
   assign Result2 = res2_q;

   // Operand magnitudes and sign flags for signed operations.
   always_comb begin
      op1_neg = MCycleOp[0] & Operand1[WIDTH-1];
      op2_neg = MCycleOp[0] & Operand2[WIDTH-1];
      op1_abs = op1_neg ? (-Operand1) : Operand1;
      op2_abs = op2_neg ? (-Operand2) : Operand2;
   end

   // One radix-2 iteration on the working registers.
   always_comb begin
      mul_sum  = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, b_q});
      div_rem  = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_rem - {1'b0, b_q};
      if (is_div_q) begin
         if (!div_diff[WIDTH]) begin
            hi_n = div_diff[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = div_rem[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_n = mul_sum[WIDTH:1];
         lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Sign fix-up and divide-by-zero override applied to the final step.
   // A zero divisor leaves the dividend magnitude in hi, so the normal
   // remainder fix-up hands back Operand1 unchanged.
   always_comb begin
      prod     = {hi_n, lo_n};
      prod_fix = (a_neg_q ^ b_neg_q) ? (-prod) : prod;
      if (is_div_q) begin
         if (div_zero_q)
            fix1 = '1;
         else
            fix1 = (a_neg_q ^ b_neg_q) ? (-lo_n) : lo_n;
         fix2 = a_neg_q ? (-hi_n) : hi_n;
      end else begin
         fix1 = prod_fix[WIDTH-1:0];
         fix2 = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state and datapath load decisions.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      a_neg_d    = a_neg_q;
      b_neg_d    = b_neg_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      b_d        = b_q;
      res1_d     = res1_q;
      res2_d     = res2_q;
      done_d     = 1'b0;
      case (state_q)
         S_COMPUTE: begin
            hi_d  = hi_n;
            lo_d  = lo_n;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = S_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
               res1_d  = fix1;
               res2_d  = fix2;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (accept) begin
               state_d    = S_COMPUTE;
               cnt_d      = '0;
               is_div_d   = MCycleOp[1];
               a_neg_d    = op1_neg;
               b_neg_d    = op2_neg;
               div_zero_d = (Operand2 == '0);
               hi_d       = '0;
               lo_d       = MCycleOp[1] ? op1_abs : op2_abs;
               b_d        = MCycleOp[1] ? op2_abs : op1_abs;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         a_neg_q    <= 1'b0;
         b_neg_q    <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         b_q        <= '0;
         res1_q     <= '0;
         res2_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         a_neg_q    <= a_neg_d;
         b_neg_q    <= b_neg_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         b_q        <= b_d;
         res1_q     <= res1_d;
         res2_q     <= res2_d;
         done_q     <= done_d;
      end
   end

endmodule
